// File: rtl/a2d_intf_if.sv
// -----------------------------------------------------------------------------
// a2d_intf_if
//   Bundles the conversion handshake (motion controller side) and the four SPI
//   pins of the external ADC into one port.
//
//   Signals:
//     start_conv  one-cycle conversion request
//     chnnl[2:0]  ADC channel to convert, sampled with start_conv
//     cnv_cmplt   level, result valid
//     res[11:0]   conversion result
//     SS_n        ADC slave select, active low
//     SCLK        SPI clock, idles high
//     MOSI        command bits to the ADC, MSB first
//     MISO        data bits from the ADC, MSB first
//
//   Modports:
//     slave   the converter block (accepts requests, drives the SPI pins)
//     master  the environment (issues requests, plays the ADC on MISO)
// -----------------------------------------------------------------------------
interface a2d_intf_if;
  logic        start_conv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport slave (
    input  start_conv, chnnl, MISO,
    output cnv_cmplt, res, SS_n, SCLK, MOSI
  );

  modport master (
    output start_conv, chnnl, MISO,
    input  cnv_cmplt, res, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/a2d_intf.sv
// -----------------------------------------------------------------------------
// a2d_intf
//   Runs one ADC conversion per start_conv request over a 16-bit SPI frame.
//   The command word {2'b00, chnnl, 11'h000} is shifted out on MOSI while the
//   reply is shifted in from MISO; the low 12 bits of the reply become res.
//
//   Ports:
//     clk   system clock, all state on the rising edge
//     rst   asynchronous active-high reset
//     bus   a2d_intf_if.slave (start_conv, chnnl, cnv_cmplt, res,
//           SS_n, SCLK, MOSI, MISO)
//
//   Build option:
//     A2D_DUAL_XFER_EN  defined   -> two frames per conversion separated by a
//                                    32-clk gap; the ADC answers with the
//                                    channel requested in the previous frame,
//                                    so only the second reply is used.
//                       undefined -> a single frame, result from that frame.
//
//   SPI timing: SCLK is bit 4 of a 5-bit divider that runs only while SS_n is
//   low. Loading 5'b10111 at frame start gives a 9-clk front porch before the
//   first SCLK fall; MISO is sampled the clk before each rise and MOSI shifts
//   the clk before each fall.
// -----------------------------------------------------------------------------
module a2d_intf (
  input  logic      clk,
  input  logic      rst,
  a2d_intf_if.slave bus
);

  typedef enum logic [2:0] {IDLE, XFER1, GAP, XFER2, DONE} state_e;

  localparam logic [4:0] DIV_LOAD  = 5'b10111;  // frame start value
  localparam logic [4:0] DIV_HOLD  = 5'b11111;  // idle value, SCLK high
  localparam logic [4:0] DIV_SMPL  = 5'b01111;  // clk before SCLK rise
  localparam logic [4:0] BITS_LAST = 5'd16;
  localparam logic [4:0] GAP_LAST  = 5'd31;

  state_e      state_q, state_d;
  logic [4:0]  div_q, div_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [2:0]  chnnl_q, chnnl_d;
  logic        ss_n_q, ss_n_d;
  logic        cnv_cmplt_q, cnv_cmplt_d;
  logic [11:0] res_q, res_d;

  logic in_frame;
  logic smpl;
  logic shft;
  logic frame_end;
  logic unused_rx_msb;

  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  assign in_frame  = ~ss_n_q;
  assign smpl      = in_frame && (div_q == DIV_SMPL);
  // The front-porch pass through 5'b11111 happens before any bit has been
  // sampled; skipping it keeps the MSB on MOSI for the first SCLK rise.
  assign shft      = in_frame && (div_q == DIV_HOLD) && (bit_cnt_q != 5'd0);
  assign frame_end = in_frame && (bit_cnt_q == BITS_LAST);

  // The top nibble of the ADC reply carries no data.
  assign unused_rx_msb = rx_q[15];

  always_comb begin
    // NOTE: every target gets its hold value first, so no branch can leave a
    // signal unassigned and infer a latch.
    state_d     = state_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    chnnl_d     = chnnl_q;
    ss_n_d      = ss_n_q;
    cnv_cmplt_d = cnv_cmplt_q;
    res_d       = res_q;

    // SPI datapath, shared by both frames.
    if (in_frame) div_d = div_q + 5'd1;
    if (smpl) begin
      rx_d      = {rx_q[14:0], bus.MISO};
      bit_cnt_d = bit_cnt_q + 5'd1;
    end
    if (shft) tx_d = {tx_q[14:0], 1'b0};

    case (state_q)
      IDLE: begin
        if (bus.start_conv) begin
          chnnl_d     = bus.chnnl;
          cnv_cmplt_d = 1'b0;
          ss_n_d      = 1'b0;
          div_d       = DIV_LOAD;
          bit_cnt_d   = 5'd0;
          tx_d        = cmd_word(bus.chnnl);
          state_d     = XFER1;
        end
      end
      XFER1: begin
        if (frame_end) begin
          ss_n_d    = 1'b1;
          div_d     = DIV_HOLD;
          bit_cnt_d = 5'd0;
`ifdef A2D_DUAL_XFER_EN
          state_d   = GAP;
`else
          state_d   = DONE;
`endif
        end
      end
      GAP: begin
        // With SS_n high the bit counter is free and times the gap.
        if (bit_cnt_q == GAP_LAST) begin
          ss_n_d    = 1'b0;
          div_d     = DIV_LOAD;
          bit_cnt_d = 5'd0;
          tx_d      = cmd_word(chnnl_q);
          state_d   = XFER2;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      XFER2: begin
        if (frame_end) begin
          ss_n_d    = 1'b1;
          div_d     = DIV_HOLD;
          bit_cnt_d = 5'd0;
          state_d   = DONE;
        end
      end
      DONE: begin
        res_d       = rx_q[11:0];
        cnv_cmplt_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= DIV_HOLD;
      bit_cnt_q   <= 5'd0;
      tx_q        <= 16'h0000;
      rx_q        <= 16'h0000;
      chnnl_q     <= 3'd0;
      ss_n_q      <= 1'b1;
      cnv_cmplt_q <= 1'b0;
      res_q       <= 12'h000;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      chnnl_q     <= chnnl_d;
      ss_n_q      <= ss_n_d;
      cnv_cmplt_q <= cnv_cmplt_d;
      res_q       <= res_d;
    end
  end

  assign bus.SS_n      = ss_n_q;
  assign bus.SCLK      = div_q[4];
  assign bus.MOSI      = tx_q[15];
  assign bus.cnv_cmplt = cnv_cmplt_q;
  assign bus.res       = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// -----------------------------------------------------------------------------
// tb_a2d_intf
//   Self-checking bench for a2d_intf. A background ADC model serves MISO words
//   from a queue and records every SPI frame (SCLK rise count, MOSI word,
//   front porch, gap to the previous frame). Scenario tasks compare these
//   records and the handshake outputs against values computed from the
//   command/result rules. Build with +define+A2D_DUAL_XFER_EN for dual mode.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_a2d_intf;

`ifdef A2D_DUAL_XFER_EN
  localparam int N_FRAMES = 2;
`else
  localparam int N_FRAMES = 1;
`endif
  localparam int TIMEOUT = 3000;

  logic clk = 1'b0;
  logic rst;

  a2d_intf_if bus ();

  a2d_intf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------------------
  // ADC model and frame recorder
  // ---------------------------------------------------------------------------
  typedef struct {
    int          rises;
    logic [15:0] mosi;
    int          first_fall;
    int          gap;
  } frame_t;

  frame_t      frames[$];
  logic [15:0] miso_words[$];
  int          frame_starts = 0;
  int          done_pulses  = 0;

  logic        miso_drv   = 1'b0;
  logic        prev_ss_n  = 1'b1;
  logic        prev_sclk  = 1'b1;
  logic        prev_cmplt = 1'b0;
  int          start_cyc  = 0;
  int          end_cyc    = -1000;
  int          rises      = 0;
  int          first_fall = -1;
  logic [15:0] mosi_w     = 16'h0000;
  logic [15:0] adc_w      = 16'h0000;

  assign bus.MISO = miso_drv;

  always @(negedge clk) begin
    if (prev_ss_n && !bus.SS_n) begin
      start_cyc  = cyc;
      rises      = 0;
      first_fall = -1;
      mosi_w     = 16'h0000;
      frame_starts++;
      adc_w      = (miso_words.size() > 0) ? miso_words.pop_front() : 16'h0000;
      miso_drv   = adc_w[15];
    end
    if (!bus.SS_n) begin
      if (prev_sclk && !bus.SCLK && first_fall < 0) first_fall = cyc - start_cyc;
      if (!prev_sclk && bus.SCLK) begin
        mosi_w = {mosi_w[14:0], bus.MOSI};
        rises++;
        miso_drv = (rises < 16) ? adc_w[4'(15 - rises)] : 1'b0;
      end
    end
    if (!prev_ss_n && bus.SS_n) begin
      frames.push_back('{rises, mosi_w, first_fall, start_cyc - end_cyc});
      end_cyc = cyc;
    end
    if (!prev_cmplt && bus.cnv_cmplt) done_pulses++;
    prev_ss_n  = bus.SS_n;
    prev_sclk  = bus.SCLK;
    prev_cmplt = bus.cnv_cmplt;
  end

  // ---------------------------------------------------------------------------
  // Reference model: command word and result from the conversion rules
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] exp_cmd(input logic [2:0] ch);
    return 16'(int'(ch) * 2048);
  endfunction

  function automatic logic [11:0] exp_res(input logic [15:0] word);
    return 12'(int'(word) % 4096);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic start_pulse(input logic [2:0] ch);
    bus.chnnl      = ch;
    bus.start_conv = 1'b1;
    @(negedge clk);
    bus.start_conv = 1'b0;
    bus.chnnl      = ~ch;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (bus.cnv_cmplt === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_frame_start(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (frame_starts >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1;
    n_tests++;
    if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n: got %b expected 1", bus.SS_n); end
    n_tests++;
    if (bus.SCLK !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b expected 1", bus.SCLK); end
    n_tests++;
    if (bus.MOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", bus.MOSI); end
    n_tests++;
    if (bus.cnv_cmplt !== 1'b0) begin n_fail++; $display("FAIL reset_cnv_cmplt: got %b expected 0", bus.cnv_cmplt); end
    n_tests++;
    if (bus.res !== 12'h000) begin n_fail++; $display("FAIL reset_res: got %h expected 000", bus.res); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_conversion();
    logic [2:0]  ch;
    logic [15:0] w[2];
    logic [15:0] cmd;
    logic [11:0] res;
    bit          ok;
    for (int it = 0; it < 5; it++) begin
      ch   = 3'($urandom_range(0, 7));
      w[0] = 16'($urandom);
      w[1] = 16'($urandom);
      if (it == 0) begin
`ifdef A2D_DUAL_XFER_EN
        ch   = 3'd3;
        w[1] = 16'h0ABC;
`else
        ch   = 3'd0;
        w[0] = 16'h0712;
`endif
      end
      frames.delete();
      miso_words.delete();
      done_pulses = 0;
      for (int f = 0; f < N_FRAMES; f++) miso_words.push_back(w[f]);
      cmd = exp_cmd(ch);
      res = exp_res(w[N_FRAMES-1]);

      start_pulse(ch);
      n_tests++;
      if (bus.SS_n !== 1'b0) begin n_fail++; $display("FAIL conv%0d_accept_ss_n: got %b expected 0", it, bus.SS_n); end
      n_tests++;
      if (bus.cnv_cmplt !== 1'b0) begin n_fail++; $display("FAIL conv%0d_accept_cmplt: got %b expected 0", it, bus.cnv_cmplt); end

      wait_done(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL conv%0d_timeout: no cnv_cmplt within %0d clks", it, TIMEOUT); end
      repeat (5) @(negedge clk);

      n_tests++;
      if (frames.size() != N_FRAMES) begin n_fail++; $display("FAIL conv%0d_frames: got %0d expected %0d", it, frames.size(), N_FRAMES); end
      for (int f = 0; f < frames.size(); f++) begin
        n_tests++;
        if (frames[f].rises != 16) begin n_fail++; $display("FAIL conv%0d_f%0d_rises: got %0d expected 16", it, f, frames[f].rises); end
        n_tests++;
        if (frames[f].mosi !== cmd) begin n_fail++; $display("FAIL conv%0d_f%0d_mosi: got %h expected %h", it, f, frames[f].mosi, cmd); end
        n_tests++;
        if (frames[f].first_fall != 9) begin n_fail++; $display("FAIL conv%0d_f%0d_porch: got %0d expected 9", it, f, frames[f].first_fall); end
        if (f > 0) begin
          n_tests++;
          if (frames[f].gap != 32) begin n_fail++; $display("FAIL conv%0d_f%0d_gap: got %0d expected 32", it, f, frames[f].gap); end
        end
      end
      n_tests++;
      if (bus.res !== res) begin n_fail++; $display("FAIL conv%0d_res: got %h expected %h", it, bus.res, res); end
      n_tests++;
      if (bus.cnv_cmplt !== 1'b1) begin n_fail++; $display("FAIL conv%0d_cmplt: got %b expected 1", it, bus.cnv_cmplt); end
      n_tests++;
      if (done_pulses != 1) begin n_fail++; $display("FAIL conv%0d_done_pulses: got %0d expected 1", it, done_pulses); end
    end
  endtask

  task automatic test_ignore_start();
    logic [2:0]  ch;
    logic [15:0] last_w;
    bit          ok;
    ch = 3'($urandom_range(0, 4));
    frames.delete();
    miso_words.delete();
    done_pulses = 0;
    for (int f = 0; f < N_FRAMES; f++) miso_words.push_back(16'($urandom));
    last_w = miso_words[N_FRAMES-1];

    start_pulse(ch);
    repeat (150) @(negedge clk);
    bus.chnnl      = 3'd5;
    bus.start_conv = 1'b1;
    @(negedge clk);
    bus.start_conv = 1'b0;

    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ignore_timeout: no cnv_cmplt within %0d clks", TIMEOUT); end
    repeat (40) @(negedge clk);

    n_tests++;
    if (frames.size() != N_FRAMES) begin n_fail++; $display("FAIL ignore_frames: got %0d expected %0d", frames.size(), N_FRAMES); end
    for (int f = 0; f < frames.size(); f++) begin
      n_tests++;
      if (frames[f].mosi !== exp_cmd(ch)) begin n_fail++; $display("FAIL ignore_f%0d_mosi: got %h expected %h", f, frames[f].mosi, exp_cmd(ch)); end
    end
    n_tests++;
    if (done_pulses != 1) begin n_fail++; $display("FAIL ignore_done_pulses: got %0d expected 1", done_pulses); end
    n_tests++;
    if (bus.res !== exp_res(last_w)) begin n_fail++; $display("FAIL ignore_res: got %h expected %h", bus.res, exp_res(last_w)); end
    n_tests++;
    if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL ignore_idle_ss_n: got %b expected 1", bus.SS_n); end
  endtask

  task automatic test_reset_abort();
    int base;
    bit ok;
    frames.delete();
    miso_words.delete();
    done_pulses = 0;
    for (int f = 0; f < N_FRAMES; f++) miso_words.push_back(16'($urandom));
    base = frame_starts;

    start_pulse(3'($urandom_range(0, 7)));
    wait_frame_start(base + N_FRAMES, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL abort_frame_timeout: last frame never started"); end
    repeat (100) @(negedge clk);

    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL abort_ss_n: got %b expected 1", bus.SS_n); end
    n_tests++;
    if (bus.SCLK !== 1'b1) begin n_fail++; $display("FAIL abort_sclk: got %b expected 1", bus.SCLK); end
    n_tests++;
    if (bus.res !== 12'h000) begin n_fail++; $display("FAIL abort_res: got %h expected 000", bus.res); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++;
    if (bus.cnv_cmplt !== 1'b0 || done_pulses != 0) begin
      n_fail++; $display("FAIL abort_cmplt: got %b with %0d pulses expected 0", bus.cnv_cmplt, done_pulses);
    end
    n_tests++;
    if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ss_n: got %b expected 1", bus.SS_n); end

    frames.delete();
    miso_words.delete();
    for (int f = 0; f < N_FRAMES - 1; f++) miso_words.push_back(16'($urandom));
    miso_words.push_back(16'hF123);
    start_pulse(3'd7);
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL abort_restart_timeout: no cnv_cmplt within %0d clks", TIMEOUT); end
    repeat (2) @(negedge clk);
    n_tests++;
    if (frames.size() != N_FRAMES) begin n_fail++; $display("FAIL abort_restart_frames: got %0d expected %0d", frames.size(), N_FRAMES); end
    if (frames.size() > 0) begin
      n_tests++;
      if (frames[0].mosi !== exp_cmd(3'd7)) begin n_fail++; $display("FAIL abort_restart_mosi: got %h expected %h", frames[0].mosi, exp_cmd(3'd7)); end
    end
    n_tests++;
    if (bus.res !== 12'h123) begin n_fail++; $display("FAIL abort_restart_res: got %h expected 123", bus.res); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ch1, ch2;
    logic [15:0] w1, w2;
    int          base;
    bit          ok;
    ch1 = 3'($urandom_range(0, 7));
    ch2 = 3'($urandom_range(0, 7));
    frames.delete();
    miso_words.delete();
    done_pulses = 0;
    for (int f = 0; f < N_FRAMES; f++) miso_words.push_back(16'($urandom));
    w1 = miso_words[N_FRAMES-1];
    for (int f = 0; f < N_FRAMES; f++) miso_words.push_back(16'($urandom));
    w2 = miso_words[2*N_FRAMES-1];
    base = frame_starts;

    start_pulse(ch1);
    wait_frame_start(base + N_FRAMES, ok);
    for (int i = 0; i < TIMEOUT && ok; i++) begin
      if (bus.SS_n === 1'b1) break;
      @(negedge clk);
    end
    n_tests++;
    if (!ok || bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL b2b_frame_end: last frame of first conversion not seen"); end

    // The clk now running is the DONE cycle; a request here must be dropped.
    bus.chnnl      = ch2;
    bus.start_conv = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL b2b_done_ignored: ss_n got %b expected 1", bus.SS_n); end
    n_tests++;
    if (bus.cnv_cmplt !== 1'b1) begin n_fail++; $display("FAIL b2b_first_cmplt: got %b expected 1", bus.cnv_cmplt); end
    n_tests++;
    if (bus.res !== exp_res(w1)) begin n_fail++; $display("FAIL b2b_first_res: got %h expected %h", bus.res, exp_res(w1)); end
    @(negedge clk);
    bus.start_conv = 1'b0;
    bus.chnnl      = ~ch2;
    n_tests++;
    if (bus.SS_n !== 1'b0 || bus.cnv_cmplt !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_accept: ss_n=%b cmplt=%b expected 0 0", bus.SS_n, bus.cnv_cmplt);
    end

    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_timeout: no cnv_cmplt within %0d clks", TIMEOUT); end
    repeat (5) @(negedge clk);
    n_tests++;
    if (frames.size() != 2 * N_FRAMES) begin n_fail++; $display("FAIL b2b_frames: got %0d expected %0d", frames.size(), 2 * N_FRAMES); end
    if (frames.size() > 0) begin
      n_tests++;
      if (frames[frames.size()-1].mosi !== exp_cmd(ch2)) begin
        n_fail++; $display("FAIL b2b_second_mosi: got %h expected %h", frames[frames.size()-1].mosi, exp_cmd(ch2));
      end
    end
    n_tests++;
    if (bus.res !== exp_res(w2)) begin n_fail++; $display("FAIL b2b_second_res: got %h expected %h", bus.res, exp_res(w2)); end
    n_tests++;
    if (done_pulses != 2) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_pulses); end
  endtask

  initial begin
    rst            = 1'b1;
    bus.start_conv = 1'b0;
    bus.chnnl      = 3'd0;
    test_reset();
    test_conversion();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_intf.md
A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start_conv, input, 1, one-cycle conversion request from motion controller.
REQ-004 SHALL have port chnnl, input, 3, A2D channel to convert; sampled when start_conv accepted.
REQ-005 SHALL have port cnv_cmplt, output, 1, level: result valid.
REQ-006 SHALL have port res, output, 12, conversion result.
REQ-007 SHALL have port SS_n, output, 1, ADC slave select, active low.
REQ-008 SHALL have port SCLK, output, 1, SPI serial clock, idle high.
REQ-009 SHALL have port MOSI, output, 1, serial command to ADC, MSB first.
REQ-010 SHALL have port MISO, input, 1, serial data from ADC, MSB first.

Function
REQ-011 SHALL implement FSM states IDLE, XFER1, GAP, XFER2, DONE; encoding free.
REQ-012 IDLE: start_conv=1 -> latch chnnl, clear cnv_cmplt, drop SS_n, load SCLK divider to 5'b10111, go XFER1.
REQ-013 start_conv while not IDLE SHALL be ignored; latched channel unchanged.
REQ-014 SCLK SHALL equal bit 4 of a 5-bit divider that increments every clk while SS_n low; period 32 clks; divider held at 5'b11111 (SCLK high) while SS_n high.
REQ-015 First SCLK fall SHALL occur 9 clks after SS_n falls (front porch).
REQ-016 MISO SHALL be sampled into a 16-bit shift register on the clk where divider==5'b01111 (cycle before SCLK rise).
REQ-017 MOSI SHALL shift on the clk where divider==5'b11111 while SS_n low (cycle before SCLK fall); MOSI = shift-register MSB.
REQ-018 Transmit word SHALL be {2'b00, chnnl, 11'h000}, loaded at frame start.
REQ-019 A 5-bit bit counter SHALL count samples; frame ends the clk after the 16th sample: SS_n high, SCLK high.
REQ-020 XFER1 end -> GAP; GAP SHALL hold SS_n high exactly 32 clks, then drop SS_n and enter XFER2 (same framing, same command word).
REQ-021 XFER2 end -> DONE; DONE SHALL load res = rx[11:0], set cnv_cmplt, return to IDLE next clk.
REQ-022 cnv_cmplt SHALL stay high until next accepted start_conv or reset; res SHALL hold until next DONE.
REQ-023 start_conv in same clk as DONE SHALL be ignored; accepted from IDLE the following clk.
REQ-024 rx[15:12] SHALL be discarded; no width extension or sign handling.

Reset
REQ-025 rst high SHALL immediately force: state IDLE, SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=12'h000, counters cleared, divider 5'b11111.
REQ-026 rst asserted mid-frame SHALL abort; no cnv_cmplt; next start_conv after release starts a fresh XFER1.

Configuration
REQ-027 Macro A2D_DUAL_XFER_EN defined: two-frame sequence per REQ-020/021 (ADC returns previous-frame channel).
REQ-028 A2D_DUAL_XFER_EN undefined: GAP and XFER2 omitted; XFER1 end -> DONE, res from XFER1 data; all other timing unchanged.

Verification
REQ-029 Reset: rst=1 at t0 -> SS_n=1, SCLK=1, cnv_cmplt=0, res=0 without clk edge.
REQ-030 Dual mode, chnnl=3, ADC model returns 16'h0ABC in frame 2 -> MOSI frames both 16'h1800, res=12'hABC, cnv_cmplt=1, one DONE pulse only.
REQ-031 Framing: count 16 SCLK rises per frame, SS_n high 32 clks between frames, first SCLK fall 9 clks after SS_n fall.
REQ-032 start_conv pulsed mid-XFER1 with chnnl=5 -> ignored; command still carries original channel; single result.
REQ-033 rst pulsed mid-XFER2 -> SS_n high immediately, cnv_cmplt stays 0; next start_conv (chnnl=7, MISO 16'hF123) -> res=12'h123.
REQ-034 Single mode (macro undefined), chnnl=0, MISO 16'h0712 -> one frame only, res=12'h712, cnv_cmplt=1.
